div_req_seq: RTL and testbench
==============================

Name: div_req_seq

Overview:
Request sequencer that sits directly upstream of the Newton-Raphson divider core. It accepts RISC-V M-extension divide/remainder ops (DIV, DIVU, REM, REMU) from the execute stage over a valid/ready handshake. It resolves the architecturally defined special cases locally, launches the core for all other ops and waits for core completion under a timeout. It then returns one tagged result per request over a valid/ready response channel.

Parameters:
WIDTH, 32, operand and result width
TAG_W, 5, request tag width (destination register ID)
TIMEOUT_CYCLES, 64, maximum cycles spent in WAIT before abort; must be >= 2

Ports:
clk_i  in  1  posedge clock
rst_i  in  1  synchronous active-high reset
req_valid_i  in  1  request valid
req_ready_o  out  1  sequencer can accept a request
req_op_i  in  2  00 DIV, 01 DIVU, 10 REM, 11 REMU
req_rs1_i  in  WIDTH  dividend
req_rs2_i  in  WIDTH  divisor
req_tag_i  in  TAG_W  request tag
core_start_o  out  1  one-cycle launch pulse to core valid_i
core_unsigned_o  out  1  = req_op[0], latched
core_out_type_o  out  1  1 quotient, 0 remainder; = ~req_op[1], latched
core_n_o  out  WIDTH  latched dividend
core_d_o  out  WIDTH  latched divisor
core_ready_i  in  1  core completion
core_q_i  in  WIDTH  core quotient
core_r_i  in  WIDTH  core remainder
core_error_i  in  2  core error code
resp_valid_o  out  1  response valid
resp_ready_i  in  1  consumer accepts response
resp_data_o  out  WIDTH  result
resp_tag_o  out  TAG_W  tag of the request
resp_error_o  out  2  00 ok, 01 divide-by-zero, 10 timeout, 11 core fault

Behaviour:
- Reset state: state=IDLE. All outputs 0 except req_ready_o=1. Latched operands, tag and timeout counter are cleared. Reset mid-operation abandons the in-flight request with no response; the core is not notified.
- States: IDLE, LAUNCH, WAIT, RESP (2-bit encoding).
- req_ready_o = (state==IDLE). Accept = req_valid_i & req_ready_o. On accept, latch op, rs1, rs2 and tag.
- IDLE, accept with rs2==0:
  - resp_data = all ones for DIV/DIVU; rs1 for REM/REMU.
  - resp_error=01.
  - Next state RESP; resp_valid_o is high the cycle after accept.
- IDLE, accept with signed op (DIV/REM), rs1 = 1 followed by WIDTH-1 zeros and rs2 = all ones:
  - resp_data = rs1 for DIV; 0 for REM.
  - resp_error=00.
  - Next state RESP.
- IDLE, any other accept: next state LAUNCH.
- LAUNCH:
  - core_start_o=1 for exactly this cycle.
  - Timeout counter cleared.
  - Next state WAIT.
- WAIT: core_n_o, core_d_o, core_unsigned_o and core_out_type_o stay stable.
  - core_ready_i=1: capture core_r_i if op[1], else core_q_i.
    - resp_error = 11 if core_error_i != 0, else 00. Next state RESP.
  - Otherwise the counter increments. When it reaches TIMEOUT_CYCLES-1 without core_ready_i: resp_data=0, resp_error=10, next state RESP.
  - core_ready_i takes priority over timeout in the same cycle.
- RESP:
  - resp_valid_o=1; resp_data_o, resp_tag_o and resp_error_o are registered and held stable until resp_ready_i.
  - On handshake, next state IDLE. No new request is accepted in the same cycle, so the minimum issue interval is 2 cycles.
- core_ready_i outside WAIT is ignored.
- The sequencer applies no sign correction; the core's q/r are final.
- Latency: special case resp_valid at accept+1. Normal path: core_start at accept+1; resp_valid 1 cycle after the core_ready_i cycle.

Test Plan:
- DIVU 100/7, tag 3; core returns q=14, r=2 after 5 cycles -> core_start one pulse at accept+1, core_out_type_o=1, core_unsigned_o=1; resp_data=14, tag=3, error=00, one cycle after core_ready.
- REM -7/2 (rs1=0xFFFFFFF9); core returns r=0xFFFFFFFF -> core_out_type_o=0, core_unsigned_o=0; resp_data=0xFFFFFFFF, error=00.
- DIV 5/0 then REMU 5/0 -> no core_start; resp_data=0xFFFFFFFF then 0x00000005, both error=01, each at accept+1.
- DIV 0x80000000/0xFFFFFFFF -> no core_start; resp_data=0x80000000, error=00. REM with the same operands -> resp_data=0.
- DIV 9/3 with core_ready_i never asserted, TIMEOUT_CYCLES=8 -> resp_valid with data=0, error=10 after 8 WAIT cycles. Repeat with core_error_i=01 on core_ready -> error=11.
- Hold resp_ready_i low 4 cycles with req_valid_i high -> resp outputs stable, req_ready_o=0. Assert rst_i in WAIT -> next cycle IDLE, resp_valid_o=0, req_ready_o=1.

Source files
------------

// File: rtl/div_req_seq.sv
// Request sequencer in front of the Newton-Raphson divider core.
// Resolves RISC-V divide-by-zero and signed-overflow cases locally, launches
// the core for everything else, waits for completion under a timeout and
// returns one tagged response per request.
module div_req_seq #(
    parameter int unsigned WIDTH          = 32,
    parameter int unsigned TAG_W          = 5,
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             req_valid_i,
    output logic             req_ready_o,
    input  logic [1:0]       req_op_i,
    input  logic [WIDTH-1:0] req_rs1_i,
    input  logic [WIDTH-1:0] req_rs2_i,
    input  logic [TAG_W-1:0] req_tag_i,
    output logic             core_start_o,
    output logic             core_unsigned_o,
    output logic             core_out_type_o,
    output logic [WIDTH-1:0] core_n_o,
    output logic [WIDTH-1:0] core_d_o,
    input  logic             core_ready_i,
    input  logic [WIDTH-1:0] core_q_i,
    input  logic [WIDTH-1:0] core_r_i,
    input  logic [1:0]       core_error_i,
    output logic             resp_valid_o,
    input  logic             resp_ready_i,
    output logic [WIDTH-1:0] resp_data_o,
    output logic [TAG_W-1:0] resp_tag_o,
    output logic [1:0]       resp_error_o
);

    localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [WIDTH-1:0] MIN_INT  = {1'b1, {(WIDTH-1){1'b0}}};

    localparam logic [1:0] ERR_OK      = 2'b00;
    localparam logic [1:0] ERR_DIV0    = 2'b01;
    localparam logic [1:0] ERR_TIMEOUT = 2'b10;
    localparam logic [1:0] ERR_FAULT   = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LAUNCH = 2'd1,
        ST_WAIT   = 2'd2,
        ST_RESP   = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic               unsigned_q, unsigned_d;
    logic               out_type_q, out_type_d;
    logic [WIDTH-1:0]   n_q, n_d;
    logic [WIDTH-1:0]   d_q, d_d;
    logic [TAG_W-1:0]   tag_q, tag_d;
    logic [WIDTH-1:0]   data_q, data_d;
    logic [1:0]         err_q, err_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               req_ready_q, core_start_q, resp_valid_q;

    // Next-state, operand latching and result selection
    always_comb begin
        state_d    = state_q;
        unsigned_d = unsigned_q;
        out_type_d = out_type_q;
        n_d        = n_q;
        d_d        = d_q;
        tag_d      = tag_q;
        data_d     = data_q;
        err_d      = err_q;
        cnt_d      = cnt_q;

        case (state_q)
            ST_IDLE: begin
                if (req_valid_i) begin
                    unsigned_d = req_op_i[0];
                    out_type_d = ~req_op_i[1];
                    n_d        = req_rs1_i;
                    d_d        = req_rs2_i;
                    tag_d      = req_tag_i;
                    if (req_rs2_i == '0) begin
                        // x/0 = all ones, x%0 = x
                        data_d  = req_op_i[1] ? req_rs1_i : '1;
                        err_d   = ERR_DIV0;
                        state_d = ST_RESP;
                    end else if (!req_op_i[0] && req_rs1_i == MIN_INT && req_rs2_i == '1) begin
                        // Signed overflow: MIN/-1 = MIN, MIN%-1 = 0
                        data_d  = req_op_i[1] ? '0 : req_rs1_i;
                        err_d   = ERR_OK;
                        state_d = ST_RESP;
                    end else begin
                        state_d = ST_LAUNCH;
                    end
                end
            end
            ST_LAUNCH: begin
                cnt_d   = '0;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (core_ready_i) begin
                    data_d  = out_type_q ? core_q_i : core_r_i;
                    err_d   = (core_error_i != 2'b00) ? ERR_FAULT : ERR_OK;
                    state_d = ST_RESP;
                end else if (cnt_q == CNT_LAST) begin
                    data_d  = '0;
                    err_d   = ERR_TIMEOUT;
                    state_d = ST_RESP;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_RESP: begin
                if (resp_ready_i) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and datapath registers with synchronous reset
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= ST_IDLE;
            unsigned_q   <= 1'b0;
            out_type_q   <= 1'b0;
            n_q          <= '0;
            d_q          <= '0;
            tag_q        <= '0;
            data_q       <= '0;
            err_q        <= 2'b00;
            cnt_q        <= '0;
            req_ready_q  <= 1'b1;
            core_start_q <= 1'b0;
            resp_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            unsigned_q   <= unsigned_d;
            out_type_q   <= out_type_d;
            n_q          <= n_d;
            d_q          <= d_d;
            tag_q        <= tag_d;
            data_q       <= data_d;
            err_q        <= err_d;
            cnt_q        <= cnt_d;
            req_ready_q  <= (state_d == ST_IDLE);
            core_start_q <= (state_d == ST_LAUNCH);
            resp_valid_q <= (state_d == ST_RESP);
        end
    end

    assign req_ready_o     = req_ready_q;
    assign core_start_o    = core_start_q;
    assign core_unsigned_o = unsigned_q;
    assign core_out_type_o = out_type_q;
    assign core_n_o        = n_q;
    assign core_d_o        = d_q;
    assign resp_valid_o    = resp_valid_q;
    assign resp_data_o     = data_q;
    assign resp_tag_o      = tag_q;
    assign resp_error_o    = err_q;

endmodule

// File: tb/tb_div_req_seq.sv
// Self-checking bench for div_req_seq with a behavioural core stand-in.
module tb_div_req_seq;

    localparam int unsigned W  = 32;
    localparam int unsigned TW = 5;
    localparam int unsigned TO = 8;

    logic          clk_i = 1'b0;
    logic          rst_i = 1'b1;
    logic          req_valid_i = 1'b0;
    logic          req_ready_o;
    logic [1:0]    req_op_i = 2'b00;
    logic [W-1:0]  req_rs1_i = '0;
    logic [W-1:0]  req_rs2_i = '0;
    logic [TW-1:0] req_tag_i = '0;
    logic          core_start_o, core_unsigned_o, core_out_type_o;
    logic [W-1:0]  core_n_o, core_d_o;
    logic          core_ready_i = 1'b0;
    logic [W-1:0]  core_q_i = '0;
    logic [W-1:0]  core_r_i = '0;
    logic [1:0]    core_error_i = 2'b00;
    logic          resp_valid_o;
    logic          resp_ready_i = 1'b0;
    logic [W-1:0]  resp_data_o;
    logic [TW-1:0] resp_tag_o;
    logic [1:0]    resp_error_o;

    int n_total = 0;
    int n_pass  = 0;

    div_req_seq #(.WIDTH(W), .TAG_W(TW), .TIMEOUT_CYCLES(TO)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_op_i(req_op_i),
        .req_rs1_i(req_rs1_i), .req_rs2_i(req_rs2_i), .req_tag_i(req_tag_i),
        .core_start_o(core_start_o), .core_unsigned_o(core_unsigned_o),
        .core_out_type_o(core_out_type_o), .core_n_o(core_n_o), .core_d_o(core_d_o),
        .core_ready_i(core_ready_i), .core_q_i(core_q_i), .core_r_i(core_r_i),
        .core_error_i(core_error_i),
        .resp_valid_o(resp_valid_o), .resp_ready_i(resp_ready_i),
        .resp_data_o(resp_data_o), .resp_tag_o(resp_tag_o), .resp_error_o(resp_error_o)
    );

    always #5 clk_i = ~clk_i;

    // One request from IDLE to response handshake; delay = WAIT cycle index of
    // core_ready (>= TO means never), hold = cycles resp_ready stays low.
    task automatic run_txn(input logic [1:0] op, input logic [W-1:0] rs1, input logic [W-1:0] rs2,
                           input logic [TW-1:0] tag, input int delay, input logic [1:0] cerr,
                           input int hold, input bit stall_req);
        logic [W-1:0] q, r, exp_data;
        logic [1:0]   exp_err;
        bit           special;
        int           nw;
        q = '0; r = '0; special = 1'b0;
        // Reference: RISC-V M-extension rules plus timeout/fault policy
        if (rs2 == 0) begin
            special = 1'b1; exp_err = 2'b01;
            exp_data = op[1] ? rs1 : 32'hFFFF_FFFF;
        end else if (!op[0] && rs1 == 32'h8000_0000 && rs2 == 32'hFFFF_FFFF) begin
            special = 1'b1; exp_err = 2'b00;
            exp_data = op[1] ? 32'd0 : rs1;
        end else begin
            if (op[0]) begin q = rs1 / rs2; r = rs1 % rs2; end
            else begin q = $signed(rs1) / $signed(rs2); r = $signed(rs1) % $signed(rs2); end
            if (delay < int'(TO)) begin
                exp_data = op[1] ? r : q;
                exp_err  = (cerr != 2'b00) ? 2'b11 : 2'b00;
            end else begin
                exp_data = 32'd0; exp_err = 2'b10;
            end
        end

        n_total++;
        if (req_ready_o !== 1'b1) $display("FAIL issue_ready: got %b want 1", req_ready_o);
        else n_pass++;
        req_valid_i = 1'b1; req_op_i = op; req_rs1_i = rs1; req_rs2_i = rs2; req_tag_i = tag;
        @(negedge clk_i);
        req_valid_i = 1'b0; req_op_i = 2'($urandom); req_rs1_i = $urandom; req_rs2_i = $urandom;
        req_tag_i = TW'($urandom);

        if (special) begin
            n_total++;
            if (core_start_o !== 1'b0 || resp_valid_o !== 1'b1)
                $display("FAIL special_latency: start=%b valid=%b want start=0 valid=1", core_start_o, resp_valid_o);
            else n_pass++;
        end else begin
            n_total++;
            if (core_start_o !== 1'b1 || resp_valid_o !== 1'b0 || core_n_o !== rs1 || core_d_o !== rs2 ||
                core_unsigned_o !== op[0] || core_out_type_o !== ~op[1])
                $display("FAIL launch: start=%b n=%h d=%h uns=%b type=%b want 1 %h %h %b %b",
                         core_start_o, core_n_o, core_d_o, core_unsigned_o, core_out_type_o,
                         rs1, rs2, op[0], ~op[1]);
            else n_pass++;
            nw = (delay < int'(TO)) ? delay + 1 : int'(TO);
            for (int k = 0; k < nw; k++) begin
                @(negedge clk_i);
                n_total++;
                if (core_start_o !== 1'b0 || resp_valid_o !== 1'b0 || core_n_o !== rs1 || core_d_o !== rs2)
                    $display("FAIL wait_%0d: start=%b valid=%b n=%h d=%h want 0 0 %h %h",
                             k, core_start_o, resp_valid_o, core_n_o, core_d_o, rs1, rs2);
                else n_pass++;
                core_ready_i = (k == delay);
                core_q_i = q; core_r_i = r; core_error_i = cerr;
            end
            @(negedge clk_i);
            core_ready_i = 1'b0; core_q_i = $urandom; core_r_i = $urandom; core_error_i = 2'b00;
        end

        n_total++;
        if (resp_valid_o !== 1'b1 || resp_data_o !== exp_data || resp_tag_o !== tag || resp_error_o !== exp_err)
            $display("FAIL resp: valid=%b data=%h tag=%0d err=%b want 1 %h %0d %b",
                     resp_valid_o, resp_data_o, resp_tag_o, resp_error_o, exp_data, tag, exp_err);
        else n_pass++;

        req_valid_i = stall_req;
        for (int h = 0; h < hold; h++) begin
            @(negedge clk_i);
            n_total++;
            if (resp_valid_o !== 1'b1 || resp_data_o !== exp_data || resp_tag_o !== tag ||
                resp_error_o !== exp_err || req_ready_o !== 1'b0)
                $display("FAIL hold_%0d: valid=%b data=%h tag=%0d err=%b rdy=%b want 1 %h %0d %b 0",
                         h, resp_valid_o, resp_data_o, resp_tag_o, resp_error_o, req_ready_o,
                         exp_data, tag, exp_err);
            else n_pass++;
        end
        resp_ready_i = 1'b1;
        @(negedge clk_i);
        resp_ready_i = 1'b0; req_valid_i = 1'b0;
        n_total++;
        if (resp_valid_o !== 1'b0 || req_ready_o !== 1'b1 || core_start_o !== 1'b0)
            $display("FAIL handshake: valid=%b rdy=%b start=%b want 0 1 0", resp_valid_o, req_ready_o, core_start_o);
        else n_pass++;
    endtask

    task automatic test_reset();
        rst_i = 1'b1;
        repeat (3) @(negedge clk_i);
        n_total++;
        if (req_ready_o !== 1'b1 || resp_valid_o !== 1'b0 || core_start_o !== 1'b0)
            $display("FAIL reset_ctrl: rdy=%b valid=%b start=%b want 1 0 0", req_ready_o, resp_valid_o, core_start_o);
        else n_pass++;
        n_total++;
        if (core_n_o !== '0 || core_d_o !== '0 || core_unsigned_o !== 1'b0 || core_out_type_o !== 1'b0 ||
            resp_data_o !== '0 || resp_tag_o !== '0 || resp_error_o !== 2'b00)
            $display("FAIL reset_data: n=%h d=%h uns=%b type=%b data=%h tag=%0d err=%b want all 0",
                     core_n_o, core_d_o, core_unsigned_o, core_out_type_o, resp_data_o, resp_tag_o, resp_error_o);
        else n_pass++;
        rst_i = 1'b0;
        @(negedge clk_i);
    endtask

    task automatic test_directed();
        run_txn(2'b01, 32'd100, 32'd7, 5'd3, 4, 2'b00, 0, 1'b0);          // DIVU 100/7
        run_txn(2'b10, 32'hFFFF_FFF9, 32'd2, 5'd4, 2, 2'b00, 0, 1'b0);    // REM -7/2
        run_txn(2'b00, 32'd5, 32'd0, 5'd5, 0, 2'b00, 0, 1'b0);            // DIV 5/0
        run_txn(2'b11, 32'd5, 32'd0, 5'd6, 0, 2'b00, 0, 1'b0);            // REMU 5/0
        run_txn(2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 5'd7, 0, 2'b00, 0, 1'b0);
        run_txn(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 5'd8, 0, 2'b00, 0, 1'b0);
        run_txn(2'b01, 32'h8000_0000, 32'hFFFF_FFFF, 5'd9, 1, 2'b00, 0, 1'b0); // unsigned: not special
    endtask

    task automatic test_timeout_fault();
        run_txn(2'b00, 32'd9, 32'd3, 5'd10, 1000, 2'b00, 0, 1'b0);        // never ready
        run_txn(2'b00, 32'd9, 32'd3, 5'd11, 3, 2'b01, 0, 1'b0);           // core fault
        run_txn(2'b00, 32'd9, 32'd3, 5'd12, int'(TO) - 1, 2'b00, 0, 1'b0); // ready on last WAIT cycle wins
    endtask

    task automatic test_stall();
        run_txn(2'b01, 32'd50, 32'd5, 5'd13, 1, 2'b00, 4, 1'b1);
    endtask

    task automatic test_reset_in_wait();
        req_valid_i = 1'b1; req_op_i = 2'b01; req_rs1_i = 32'd77; req_rs2_i = 32'd7; req_tag_i = 5'd14;
        @(negedge clk_i);
        req_valid_i = 1'b0;
        repeat (2) @(negedge clk_i);
        rst_i = 1'b1;
        core_ready_i = 1'b1; core_q_i = 32'd11;
        @(negedge clk_i);
        rst_i = 1'b0; core_ready_i = 1'b0;
        n_total++;
        if (resp_valid_o !== 1'b0 || req_ready_o !== 1'b1 || core_start_o !== 1'b0 || core_n_o !== '0)
            $display("FAIL reset_wait: valid=%b rdy=%b start=%b n=%h want 0 1 0 0",
                     resp_valid_o, req_ready_o, core_start_o, core_n_o);
        else n_pass++;
        // core_ready while idle must not produce anything
        core_ready_i = 1'b1;
        repeat (2) @(negedge clk_i);
        core_ready_i = 1'b0;
        n_total++;
        if (resp_valid_o !== 1'b0 || req_ready_o !== 1'b1)
            $display("FAIL idle_ready_ignored: valid=%b rdy=%b want 0 1", resp_valid_o, req_ready_o);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        logic [1:0]   op;
        logic [W-1:0] a, b;
        int           sel;
        for (int i = 0; i < 40; i++) begin
            op  = 2'($urandom);
            a   = $urandom;
            b   = $urandom;
            sel = $urandom_range(0, 7);
            if (sel == 0) b = '0;
            else if (sel == 1) begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
            else if (sel == 2) b = 32'($urandom_range(1, 20));
            run_txn(op, a, b, TW'($urandom), $urandom_range(0, 10),
                    ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00,
                    $urandom_range(0, 2), 1'($urandom));
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_timeout_fault();
        test_stall();
        test_reset_in_wait();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
